// File: rtl/jzjpcc_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous
// instruction memory and hands {instruction, pc} to decode.
module jzjpcc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_decode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction_decode,
    output logic [31:0] pc_decode,
    output logic [31:0] pc_plus4_decode,
    output logic        valid_decode,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        misaligned;

    assign misaligned = redirect_target[1:0] != 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        unique case (state_q)
            BOOT: begin
                // Re-read the reset vector so imem_data is valid regardless
                // of what the memory does while in reset.
                pc_d    = RESET_VECTOR;
                valid_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (stall_decode) begin
                    pc_d = pc_q;
                end else if (redirect_valid && misaligned) begin
                    state_d    = HALT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_target;
                    valid_d    = 1'b0;
                    pc_d       = pc_q;
                end else if (redirect_valid) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b1;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                end
            end
            HALT: begin
                pc_d    = pc_q;
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VECTOR;
                valid_d = 1'b0;
            end
        endcase
    end

    // The read address follows pc_d so the next word is ready at the edge.
    assign imem_addr          = reset ? RESET_VECTOR[31:2] : pc_d[31:2];
    assign instruction_decode = valid_q ? imem_data : NOP_INSTRUCTION;
    assign pc_decode          = pc_q;
    assign pc_plus4_decode    = pc_q + 32'd4;
    assign valid_decode       = valid_q;
    assign fetch_fault        = fault_q;
    assign fault_pc           = fault_pc_q;

endmodule
